// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage RV32I hazard controller: stalls, flushes, forwarding, mem-wait FSM, perf counters
module hazard_ctrl #(
    parameter int REG_WIDTH   = 5,
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] id_rs1,
    input  logic [REG_WIDTH-1:0] id_rs2,
    input  logic [REG_WIDTH-1:0] ex_rs1,
    input  logic [REG_WIDTH-1:0] ex_rs2,
    input  logic [REG_WIDTH-1:0] ex_rd,
    input  logic [1:0]           ex_result_src,
    input  logic                 ex_pc_src,
    input  logic [REG_WIDTH-1:0] mem_rd,
    input  logic                 mem_reg_write,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic [REG_WIDTH-1:0] wb_rd,
    input  logic                 wb_reg_write,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 stall_m,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 flush_w,
    output logic [1:0]           fwd_a_e,
    output logic [1:0]           fwd_b_e,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]    WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]    WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 mem_timeout_q, mem_timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall;
    logic load_use;

    always_comb begin
        mem_stall = 1'b0;
        if (state_q == RUN) begin
            mem_stall = mem_req & ~mem_ready;
        end else begin
            mem_stall = ~mem_ready;
        end
    end

    assign load_use = (ex_result_src == 2'b01) && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // MEM result is younger than WB, so it wins when both target the same register.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (!rst) begin
            if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs1) begin
                fwd_a_e = 2'b10;
            end else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs1) begin
                fwd_a_e = 2'b01;
            end
            if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs2) begin
                fwd_b_e = 2'b10;
            end else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs2) begin
                fwd_b_e = 2'b01;
            end
        end
    end

    // A frozen EX stage means load-use and branch decisions are stale, so the memory stall masks both.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (ex_pc_src) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
                if (wait_cnt_d == WAIT_MAX) begin
                    mem_timeout_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if ((flush_d || flush_e) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized scoreboard bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int RW    = 5;
    localparam int CW    = 4;
    localparam int MT    = 4;
    localparam int NCYC  = 600;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
    logic [1:0]    ex_result_src = '0;
    logic          ex_pc_src = 1'b0;
    logic [RW-1:0] mem_rd = '0, wb_rd = '0;
    logic          mem_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic          mem_req = 1'b0, mem_ready = 1'b0;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_w;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.REG_WIDTH(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stalls;
        int flushes;
        int fa;
        int fb;
        int tmo;
        int sc;
        int fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: are we waiting on memory, how long, and what the counters read.
    bit m_waiting = 0;
    int m_wait    = 0;
    int m_tmo     = 0;
    int m_sc      = 0;
    int m_fc      = 0;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    function automatic int fwd_of(input int rs);
        if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == rs) return 2;
        if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == rs) return 1;
        return 0;
    endfunction

    task automatic model_step();
        exp_t e;
        bit sf, sd, se, sm, fd, fe, fw;
        bit mstall, lu;
        sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0;
        e.tmo = m_tmo;
        e.sc  = m_sc;
        e.fc  = m_fc;
        if (rst) begin
            fd = 1; fe = 1; fw = 1;
            e.fa = 0;
            e.fb = 0;
        end else begin
            e.fa = fwd_of(int'(ex_rs1));
            e.fb = fwd_of(int'(ex_rs2));
            mstall = m_waiting ? !mem_ready : (mem_req && !mem_ready);
            lu = (ex_result_src == 2'b01) && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
            if (mstall) begin
                sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
            end else if (ex_pc_src) begin
                fd = 1; fe = 1;
            end else if (lu) begin
                sf = 1; sd = 1; fe = 1;
            end
        end
        e.stalls  = {sf, sd, se, sm};
        e.flushes = {fd, fe, fw};
        exp_q.push_back(e);

        if (rst) begin
            m_waiting = 0; m_wait = 0; m_tmo = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (sf) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            if (fd || fe) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            if (m_waiting) begin
                m_wait = m_wait + 1;
                if (m_wait >= MT) m_tmo = 1;
                m_waiting = !mem_ready;
            end else if (mem_req && !mem_ready) begin
                m_waiting = 1;
                m_wait    = 0;
            end
        end
    endtask

    task automatic randomize_inputs(input int i);
        id_rs1        = RW'($urandom_range(0, 3));
        id_rs2        = RW'($urandom_range(0, 3));
        ex_rs1        = RW'($urandom_range(0, 3));
        ex_rs2        = RW'($urandom_range(0, 3));
        ex_rd         = RW'($urandom_range(0, 3));
        mem_rd        = RW'($urandom_range(0, 3));
        wb_rd         = RW'($urandom_range(0, 3));
        ex_result_src = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
        ex_pc_src     = ($urandom_range(0, 4) == 0);
        mem_reg_write = ($urandom_range(0, 1) == 1);
        wb_reg_write  = ($urandom_range(0, 1) == 1);
        mem_req       = ($urandom_range(0, 3) == 0);
        mem_ready     = ($urandom_range(0, 2) != 0);
        rst           = (i > 0) && ($urandom_range(0, 49) == 0);
        // Directed windows: long memory wait, load-use burst to saturate, reset mid-wait.
        if (i >= 200 && i < 213) begin
            rst = 0; mem_req = 1; mem_ready = (i == 212);
        end else if (i >= 220 && i < 245) begin
            rst = 0; mem_req = 0; ex_pc_src = 0;
            ex_result_src = 2'b01; ex_rd = 5'd5; id_rs1 = 5'd5;
        end else if (i >= 300 && i < 306) begin
            rst = 0; mem_req = 1; mem_ready = 0;
        end else if (i == 306) begin
            rst = 1;
        end else if (i == 310) begin
            rst = 0; ex_rs1 = 5'd3; mem_rd = 5'd3; wb_rd = 5'd3;
            mem_reg_write = 1; wb_reg_write = 1;
        end else if (i == 311) begin
            rst = 0; ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
            mem_reg_write = 1; wb_reg_write = 1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stalls",  int'({stall_f, stall_d, stall_e, stall_m}), e.stalls);
                check("flushes", int'({flush_d, flush_e, flush_w}), e.flushes);
                check("fwd_a_e", int'(fwd_a_e), e.fa);
                check("fwd_b_e", int'(fwd_b_e), e.fb);
                check("mem_timeout", int'(mem_timeout), e.tmo);
                check("stall_cnt", int'(stall_cnt), e.sc);
                check("flush_cnt", int'(flush_cnt), e.fc);
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            #1;
            randomize_inputs(i);
            model_step();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_req = 1'b0;
        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
